drum_mul_scheduler: RTL

- Round-robin scheduler that shares one combinational drum approximate multiplier among N_REQ requesters.
- Each requester presents operands with a valid/ready handshake.
- The scheduler registers the granted operands onto the shared multiplier inputs and waits MUL_LAT cycles for the result to settle.
- It then returns the product on a single tagged response channel with backpressure. It sits between the operand-producing logic and the shared drum instance.

---
 rtl/drum_mul_scheduler_if.sv | 31 +++
 rtl/drum_mul_scheduler.sv | 94 +++++++++
 2 files changed

// File: rtl/drum_mul_scheduler_if.sv
// drum_mul_scheduler_if: requester, shared-multiplier and response signals of the drum scheduler
interface drum_mul_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int N     = 8,
    parameter int M     = 8
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ*N-1:0] req_a;
    logic [N_REQ*M-1:0] req_b;
    logic [N_REQ-1:0]   req_ready;
    logic [N-1:0]       mul_a;
    logic [M-1:0]       mul_b;
    logic [N+M-1:0]     mul_r;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [N+M-1:0]     rsp_r;
    logic [ID_W-1:0]    rsp_id;
    logic               busy;

    modport master (
        output req_valid, req_a, req_b, mul_r, rsp_ready,
        input  req_ready, mul_a, mul_b, rsp_valid, rsp_r, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, mul_r, rsp_ready,
        output req_ready, mul_a, mul_b, rsp_valid, rsp_r, rsp_id, busy
    );
endinterface

// File: rtl/drum_mul_scheduler.sv
// drum_mul_scheduler: round-robin sharing of one combinational drum multiplier among N_REQ requesters
module drum_mul_scheduler #(
    parameter int N_REQ   = 4,
    parameter int N       = 8,
    parameter int M       = 8,
    parameter int MUL_LAT = 1
) (
    input logic                  clk,
    input logic                  rst,
    drum_mul_scheduler_if.slave  bus
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int LAT_W = $clog2(MUL_LAT + 1);

    if (MUL_LAT < 1) begin : g_bad_lat
        $error("MUL_LAT must be at least 1");
    end
    if (N_REQ < 2 || N_REQ > 16) begin : g_bad_nreq
        $error("N_REQ must be within 2..16");
    end

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t          state, state_nx;
    logic [ID_W-1:0] rr_ptr, grant;
    logic            found;
    logic [LAT_W-1:0] lat_cnt;

    // first valid requester searching cyclically from rr_ptr
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && bus.req_valid[ID_W'((int'(rr_ptr) + i) % N_REQ)]) begin
                found = 1'b1;
                grant = ID_W'((int'(rr_ptr) + i) % N_REQ);
            end
        end
    end

    // one-hot accept, only offered while idle and out of reset
    always_comb begin
        bus.req_ready = '0;
        if (!rst && state == IDLE && found) bus.req_ready[grant] = 1'b1;
    end

    // next-state: accept, wait out the multiplier latency, then hold the response until taken
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = found ? CALC : IDLE;
            CALC:    state_nx = (lat_cnt == '0) ? RESP : CALC;
            RESP:    state_nx = bus.rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nx;
    end

    // operand capture, latency countdown, response capture and release
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr        <= '0;
            lat_cnt       <= '0;
            bus.mul_a     <= '0;
            bus.mul_b     <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_r     <= '0;
            bus.rsp_id    <= '0;
        end else begin
            if (state == IDLE && found) begin
                bus.mul_a  <= bus.req_a[grant*N +: N];
                bus.mul_b  <= bus.req_b[grant*M +: M];
                bus.rsp_id <= grant;
                rr_ptr     <= ID_W'((int'(grant) + 1) % N_REQ);
                lat_cnt    <= LAT_W'(MUL_LAT - 1);
            end
            if (state == CALC) begin
                if (lat_cnt != '0) begin
                    lat_cnt <= lat_cnt - LAT_W'(1);
                end else begin
                    bus.rsp_r     <= bus.mul_r;
                    bus.rsp_valid <= 1'b1;
                end
            end
            if (state == RESP && bus.rsp_ready) bus.rsp_valid <= 1'b0;
        end
    end

    assign bus.busy = (state != IDLE);
endmodule
